interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Sits directly upstream of instruction_decode in the 65c02 core.
- Synchronizes the external irqb/nmib lines, latches NMI edges, tracks the post-reset request and the WAI/STP halt states.
- Arbitrates pending events at instruction boundaries and hands the winner to instruction_decode as a request plus a 5-bit vector_operations code. That code drives decode's {push_vector, push_resb, push_nmib, push_irqb, reset_stack}.
- Times the service sequence with an internal cycle counter.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the irqb/nmib synchronizers (minimum 2).
- SERVICE_CYCLES, 7, length in fclk cycles of a vector-service sequence (3..7, fits seq_cycle).

Ports:
- fclk  input  1  core clock; all state updates on its rising edge.
- resb  input  1  reset. Synchronous, active-low.
- irqb  input  1  async IRQ line, active-low, level-sensitive.
- nmib  input  1  async NMI line, active-low, falling-edge-sensitive.
- rdy  input  1  65c02 RDY; low freezes FSM and counter.
- sync  input  1  opcode-fetch (instruction boundary) strobe from decode.
- i_flag  input  1  processor status I bit.
- wai_exec  input  1  decode is executing WAI (one-cycle pulse).
- stp_exec  input  1  decode is executing STP (one-cycle pulse).
- svc_ack  input  1  decode accepts the current request.
- int_req  output  1  request pending to decode.
- int_kind  output  2  00 none, 01 IRQ, 10 NMI, 11 RESET.
- vector_operations  output  5  RESET 11001, NMI 10100, IRQ 10010, else 00000.
- set_i  output  1  one-cycle pulse: set I flag.
- clear_d  output  1  one-cycle pulse: clear D flag.
- cpu_halt  output  1  high in WAIT and STOP.
- seq_cycle  output  3  service cycle index.

Behaviour:
- Reset: resb low at an edge clears synchronizers to 1 and clears nmi_latch.
  - Sets reset_pending=1 and state=IDLE.
  - Drives all outputs 0 except int_kind=00.
  - Reset mid-service or mid-WAIT/STOP aborts to this same condition.
- Synchronizers and NMI edge detect run regardless of rdy.
  - nmi_latch sets on a sync-stage 1->0 transition: SYNC_STAGES+1 cycles after the nmib fall.
  - Set wins over a simultaneous clear.
- irq_active = synchronized irqb==0 AND i_flag==0. It is not latched.
- Pending priority: RESET (reset_pending) > NMI (nmi_latch) > IRQ (irq_active).
- FSM states: IDLE, REQ, SERVICE, WAIT, STOP. With rdy=0 the state, counter and outputs hold, except cpu_halt.
- IDLE:
  - stp_exec -> STOP.
  - wai_exec -> WAIT.
  - sync=1 and a pending event -> REQ, latching int_kind.
- REQ:
  - int_req=1 and int_kind held stable.
  - An IRQ that deasserts during REQ is still serviced.
  - A later-arriving higher-priority event does not preempt.
  - On svc_ack -> SERVICE, seq_cycle=0, and clear the source: reset_pending for RESET, nmi_latch for NMI.
- SERVICE:
  - int_req=0; vector_operations = code of the latched kind.
  - seq_cycle increments per rdy cycle.
  - At seq_cycle==SERVICE_CYCLES-1: pulse set_i and clear_d for one cycle, vector_operations returns to 00000, state -> IDLE, int_kind -> 00.
  - An NMI edge during SERVICE re-latches and is serviced at the next boundary.
- WAIT:
  - cpu_halt=1.
  - Synchronized irqb==0 with i_flag=1 -> IDLE, no service.
  - Synchronized irqb==0 with i_flag=0 -> REQ IRQ.
  - nmi_latch -> REQ NMI, priority over IRQ.
- STOP: cpu_halt=1; only resb exits.

Decomposition:
- Package interrupt_pkg holds:
  - int_kind_t enum (NONE, IRQ, NMI, RESET).
  - seq_state_t enum.
  - VEC_RESET, VEC_NMI, VEC_IRQ, VEC_NONE localparams.
- One sub-module, line_synchronizer, parameterized by depth with a reset value of 1. It is instantiated twice, for irqb and nmib.

Test Plan:
- Reset release: resb 0->1, sync=1, svc_ack at the next cycle -> int_req=1, int_kind=11; then vector_operations=11001 for 7 cycles, then set_i=clear_d=1 for one cycle.
- NMI edge: nmib 1->0 held 1 cycle, sync=1 afterwards -> nmi_latch is set 3 cycles after the fall, int_kind=10, vector_operations=10100 after svc_ack. A second service does not occur without a new edge.
- IRQ masked/unmasked: irqb=0 with i_flag=1 at sync -> int_req stays 0. Drop i_flag to 0 -> int_kind=01, vector_operations=10010.
- Simultaneous: NMI edge and irqb=0 (i_flag=0) both pending at sync -> NMI serviced first; the IRQ is serviced at the next sync after SERVICE completes.
- WAI: wai_exec, then irqb=0 with i_flag=1 -> cpu_halt 1 -> 0 with no int_req. Repeat with i_flag=0 -> REQ IRQ.
- STP / rdy: stp_exec -> cpu_halt=1, unaffected by nmib/irqb, cleared only by resb=0. Separately, rdy=0 in SERVICE at seq_cycle=3 for 4 cycles -> seq_cycle stays 3 and the total service is 11 cycles.

Source files
------------

// File: rtl/interrupt_pkg.sv
// rtl/interrupt_pkg.sv - shared types and vector-operation codes for interrupt_sequencer
// Purpose: the event kinds, the sequencer state encoding and the decode vector codes.
// Ports: none (package).
package interrupt_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    IRQ   = 2'b01,
    NMI   = 2'b10,
    RESET = 2'b11
  } int_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SERVICE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_STOP    = 3'd4
  } seq_state_t;

  // Bit order: {push_vector, push_resb, push_nmib, push_irqb, reset_stack}
  localparam logic [4:0] VEC_RESET = 5'b11001;
  localparam logic [4:0] VEC_NMI   = 5'b10100;
  localparam logic [4:0] VEC_IRQ   = 5'b10010;
  localparam logic [4:0] VEC_NONE  = 5'b00000;

  function automatic logic [4:0] vec_code(input int_kind_t kind);
    case (kind)
      RESET:   return VEC_RESET;
      NMI:     return VEC_NMI;
      IRQ:     return VEC_IRQ;
      default: return VEC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/line_synchronizer.sv
// rtl/line_synchronizer.sv - multi-flop synchronizer for an active-low async line
// Purpose: brings an asynchronous active-low line into the clock domain.
// Ports:
//   i_clk    - sampling clock
//   i_resetn - synchronous active-low reset; every stage resets to 1 (line idle)
//   i_d      - asynchronous input
//   o_q      - synchronized output, DEPTH clocks behind i_d
module line_synchronizer #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_stage;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_stage <= '1;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 65c02 interrupt/reset arbitration and service sequencer
// Purpose: synchronizes irqb/nmib, latches NMI edges, tracks post-reset and WAI/STP
// halt states, arbitrates at instruction boundaries and times vector service.
// Ports:
//   fclk, resb                 - clock, synchronous active-low reset
//   irqb, nmib                 - async interrupt lines (level / falling edge)
//   rdy                        - low freezes FSM and service counter
//   sync, i_flag               - instruction boundary strobe, status I bit
//   wai_exec, stp_exec         - WAI / STP execution pulses from decode
//   svc_ack                    - decode accepts the pending request
//   int_req, int_kind          - request and kind presented to decode
//   vector_operations          - decode push/stack control code during service
//   set_i, clear_d             - one-cycle flag update pulses at end of service
//   cpu_halt, seq_cycle        - halted (WAIT/STOP), service cycle index
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SERVICE_CYCLES = 7
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       irqb,
  input  logic       nmib,
  input  logic       rdy,
  input  logic       sync,
  input  logic       i_flag,
  input  logic       wai_exec,
  input  logic       stp_exec,
  input  logic       svc_ack,
  output logic       int_req,
  output logic [1:0] int_kind,
  output logic [4:0] vector_operations,
  output logic       set_i,
  output logic       clear_d,
  output logic       cpu_halt,
  output logic [2:0] seq_cycle
);

  localparam logic [2:0] LAST_SEQ = 3'(SERVICE_CYCLES - 1);

  logic       w_irqb_s;
  logic       w_nmib_s;
  logic       w_nmi_edge;
  logic       w_nmi_clr;
  logic       w_irq_active;
  int_kind_t  w_pend;

  logic       r_nmib_prev;
  logic       r_nmi_latch;
  logic       r_reset_pending;
  seq_state_t r_state;
  int_kind_t  r_kind;
  logic [2:0] r_seq;
  logic       r_set_i;

  line_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_irqb (
    .i_clk    (fclk),
    .i_resetn (resb),
    .i_d      (irqb),
    .o_q      (w_irqb_s)
  );

  line_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_nmib (
    .i_clk    (fclk),
    .i_resetn (resb),
    .i_d      (nmib),
    .o_q      (w_nmib_s)
  );

  assign w_nmi_edge   = r_nmib_prev & ~w_nmib_s;
  assign w_irq_active = ~w_irqb_s & ~i_flag;
  // NMI source is consumed when decode accepts an NMI request.
  assign w_nmi_clr    = rdy && (r_state == ST_REQ) && svc_ack && (r_kind == NMI);

  always_comb begin
    w_pend = NONE;
    if (r_reset_pending)   w_pend = RESET;
    else if (r_nmi_latch)  w_pend = NMI;
    else if (w_irq_active) w_pend = IRQ;
  end

  // Edge detection keeps running while rdy is low so no NMI edge is lost.
  // A new edge in the same cycle as the clear wins, so it is not dropped.
  always_ff @(posedge fclk) begin
    if (!resb) begin
      r_nmib_prev <= 1'b1;
      r_nmi_latch <= 1'b0;
    end else begin
      r_nmib_prev <= w_nmib_s;
      if (w_nmi_edge) begin
        r_nmi_latch <= 1'b1;
      end else if (w_nmi_clr) begin
        r_nmi_latch <= 1'b0;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (!resb) begin
      r_state         <= ST_IDLE;
      r_kind          <= NONE;
      r_seq           <= 3'd0;
      r_set_i         <= 1'b0;
      r_reset_pending <= 1'b1;
    end else if (rdy) begin
      r_set_i <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (stp_exec) begin
            r_state <= ST_STOP;
          end else if (wai_exec) begin
            r_state <= ST_WAIT;
          end else if (sync && (w_pend != NONE)) begin
            r_state <= ST_REQ;
            r_kind  <= w_pend;
          end
        end
        // Kind is frozen here: later events or a dropped IRQ do not change it.
        ST_REQ: begin
          if (svc_ack) begin
            r_state <= ST_SERVICE;
            r_seq   <= 3'd0;
            if (r_kind == RESET) r_reset_pending <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (r_seq == LAST_SEQ) begin
            r_state <= ST_IDLE;
            r_kind  <= NONE;
            r_seq   <= 3'd0;
            r_set_i <= 1'b1;
          end else begin
            r_seq <= r_seq + 3'd1;
          end
        end
        ST_WAIT: begin
          if (r_nmi_latch) begin
            r_state <= ST_REQ;
            r_kind  <= NMI;
          end else if (!w_irqb_s) begin
            // A masked IRQ only wakes the core; it is not serviced.
            if (i_flag) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_REQ;
              r_kind  <= IRQ;
            end
          end
        end
        ST_STOP: begin
          r_state <= ST_STOP;
        end
        default: begin
          r_state <= ST_IDLE;
          r_kind  <= NONE;
        end
      endcase
    end
  end

  assign int_req           = (r_state == ST_REQ);
  assign int_kind          = r_kind;
  assign vector_operations = (r_state == ST_SERVICE) ? vec_code(r_kind) : VEC_NONE;
  assign set_i             = r_set_i;
  assign clear_d           = r_set_i;
  assign cpu_halt          = (r_state == ST_WAIT) || (r_state == ST_STOP);
  assign seq_cycle         = r_seq;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;

  localparam logic [4:0] C_RESET = 5'b11001;
  localparam logic [4:0] C_NMI   = 5'b10100;
  localparam logic [4:0] C_IRQ   = 5'b10010;

  logic       fclk = 1'b0;
  logic       resb = 1'b0;
  logic       irqb = 1'b1;
  logic       nmib = 1'b1;
  logic       rdy = 1'b1;
  logic       sync = 1'b0;
  logic       i_flag = 1'b1;
  logic       wai_exec = 1'b0;
  logic       stp_exec = 1'b0;
  logic       svc_ack = 1'b0;
  logic       int_req;
  logic [1:0] int_kind;
  logic [4:0] vector_operations;
  logic       set_i;
  logic       clear_d;
  logic       cpu_halt;
  logic [2:0] seq_cycle;

  int n_tests = 0;
  int n_fail  = 0;
  int svc_len;

  logic [13:0] exp_q[$];
  string       tag_q[$];
  logic [13:0] w_obs;

  always #5 fclk = ~fclk;

  interrupt_sequencer #(.SYNC_STAGES(2), .SERVICE_CYCLES(7)) dut (
    .fclk              (fclk),
    .resb              (resb),
    .irqb              (irqb),
    .nmib              (nmib),
    .rdy               (rdy),
    .sync              (sync),
    .i_flag            (i_flag),
    .wai_exec          (wai_exec),
    .stp_exec          (stp_exec),
    .svc_ack           (svc_ack),
    .int_req           (int_req),
    .int_kind          (int_kind),
    .vector_operations (vector_operations),
    .set_i             (set_i),
    .clear_d           (clear_d),
    .cpu_halt          (cpu_halt),
    .seq_cycle         (seq_cycle)
  );

  assign w_obs = {int_req, int_kind, vector_operations, set_i, clear_d, cpu_halt, seq_cycle};

  function automatic logic [13:0] ov(input logic req, input logic [1:0] kind,
                                     input logic [4:0] vec, input logic si,
                                     input logic halt, input logic [2:0] seq);
    return {req, kind, vec, si, si, halt, seq};
  endfunction

  task automatic push(input string tag, input logic [13:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic step();
    string       t;
    logic [13:0] e;
    @(posedge fclk);
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h required a queued entry", w_obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (w_obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, w_obs, e);
      end
    end
  endtask

  // Full service sequence as seen by decode, followed by the flag pulse cycle.
  task automatic push_service(input string tag, input logic [1:0] kind, input logic [4:0] vec);
    for (int i = 0; i < 7; i++) push(tag, ov(1'b0, kind, vec, 1'b0, 1'b0, 3'(i)));
    push({tag, "_flags"}, ov(1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 3'd0));
  endtask

  task automatic run_service(input string tag, input logic [1:0] kind, input logic [4:0] vec);
    push_service(tag, kind, vec);
    step();
    svc_ack = 1'b0;
    repeat (7) step();
  endtask

  initial begin
    // Reset dominates even with sync asserted.
    sync = 1'b1;
    repeat (3) begin push("reset", ov(0, 0, 0, 0, 0, 0)); step(); end

    // Post-reset request and RESET service.
    resb = 1'b1;
    push("rst_req", ov(1, 2'b11, 0, 0, 0, 0)); step();
    sync = 1'b0; svc_ack = 1'b1;
    run_service("rst_svc", 2'b11, C_RESET);
    sync = 1'b1;
    push("rst_once", ov(0, 0, 0, 0, 0, 0)); step();

    // NMI edge, low for one cycle; latched on the third edge, request on the fourth.
    nmib = 1'b0;
    push("nmi_sync1", ov(0, 0, 0, 0, 0, 0)); step();
    nmib = 1'b1;
    push("nmi_sync2", ov(0, 0, 0, 0, 0, 0)); step();
    push("nmi_latch", ov(0, 0, 0, 0, 0, 0)); step();
    push("nmi_req", ov(1, 2'b10, 0, 0, 0, 0)); step();
    svc_ack = 1'b1;
    run_service("nmi_svc", 2'b10, C_NMI);
    repeat (2) begin push("nmi_once", ov(0, 0, 0, 0, 0, 0)); step(); end

    // IRQ masked, then unmasked.
    irqb = 1'b0; i_flag = 1'b1;
    repeat (4) begin push("irq_masked", ov(0, 0, 0, 0, 0, 0)); step(); end
    i_flag = 1'b0;
    push("irq_req", ov(1, 2'b01, 0, 0, 0, 0)); step();
    svc_ack = 1'b1; sync = 1'b0; irqb = 1'b1; i_flag = 1'b1;
    run_service("irq_svc", 2'b01, C_IRQ);

    // Simultaneous NMI and IRQ: NMI first, IRQ at the next boundary.
    irqb = 1'b0; nmib = 1'b0; i_flag = 1'b0;
    push("sim_pre", ov(0, 0, 0, 0, 0, 0)); step();
    nmib = 1'b1;
    repeat (2) begin push("sim_pre", ov(0, 0, 0, 0, 0, 0)); step(); end
    sync = 1'b1;
    push("sim_nmi_req", ov(1, 2'b10, 0, 0, 0, 0)); step();
    sync = 1'b0; svc_ack = 1'b1;
    run_service("sim_nmi_svc", 2'b10, C_NMI);
    sync = 1'b1;
    push("sim_irq_req", ov(1, 2'b01, 0, 0, 0, 0)); step();
    sync = 1'b0; svc_ack = 1'b1; irqb = 1'b1; i_flag = 1'b1;
    run_service("sim_irq_svc", 2'b01, C_IRQ);

    // WAI woken by a masked IRQ: back to IDLE with no request.
    wai_exec = 1'b1;
    push("wai_enter", ov(0, 0, 0, 0, 1, 0)); step();
    wai_exec = 1'b0; irqb = 1'b0;
    repeat (2) begin push("wai_hold", ov(0, 0, 0, 0, 1, 0)); step(); end
    push("wai_wake_masked", ov(0, 0, 0, 0, 0, 0)); step();
    push("wai_no_req", ov(0, 0, 0, 0, 0, 0)); step();
    irqb = 1'b1;
    repeat (2) begin push("wai_idle", ov(0, 0, 0, 0, 0, 0)); step(); end

    // WAI woken by an unmasked IRQ: goes to REQ IRQ.
    i_flag = 1'b0; wai_exec = 1'b1;
    push("wai2_enter", ov(0, 0, 0, 0, 1, 0)); step();
    wai_exec = 1'b0; irqb = 1'b0;
    repeat (2) begin push("wai2_hold", ov(0, 0, 0, 0, 1, 0)); step(); end
    push("wai2_req", ov(1, 2'b01, 0, 0, 0, 0)); step();
    svc_ack = 1'b1; irqb = 1'b1; i_flag = 1'b1;
    run_service("wai2_svc", 2'b01, C_IRQ);

    // STP: immune to irqb/nmib, only reset exits.
    stp_exec = 1'b1;
    push("stp_enter", ov(0, 0, 0, 0, 1, 0)); step();
    stp_exec = 1'b0; nmib = 1'b0; irqb = 1'b0; i_flag = 1'b0; sync = 1'b1;
    repeat (6) begin push("stp_hold", ov(0, 0, 0, 0, 1, 0)); step(); end
    nmib = 1'b1; irqb = 1'b1; i_flag = 1'b1; sync = 1'b0; resb = 1'b0;
    push("stp_reset", ov(0, 0, 0, 0, 0, 0)); step();

    // RESET service with rdy low for 4 cycles at seq_cycle 3.
    resb = 1'b1; sync = 1'b1;
    push("rdy_req", ov(1, 2'b11, 0, 0, 0, 0)); step();
    sync = 1'b0; svc_ack = 1'b1;
    svc_len = 0;
    for (int i = 0; i < 4; i++) begin
      push("rdy_svc", ov(0, 2'b11, C_RESET, 0, 0, 3'(i))); step();
      svc_ack = 1'b0;
      if (vector_operations != 5'd0) svc_len++;
    end
    rdy = 1'b0;
    repeat (4) begin
      push("rdy_hold", ov(0, 2'b11, C_RESET, 0, 0, 3'd3)); step();
      if (vector_operations != 5'd0) svc_len++;
    end
    rdy = 1'b1;
    for (int i = 4; i < 7; i++) begin
      push("rdy_svc", ov(0, 2'b11, C_RESET, 0, 0, 3'(i))); step();
      if (vector_operations != 5'd0) svc_len++;
    end
    push("rdy_flags", ov(0, 0, 0, 1, 0, 0)); step();
    n_tests++;
    assert (svc_len === 11) else begin
      n_fail++;
      $error("FAIL rdy_svc_len: observed %0d expected %0d", svc_len, 11);
    end
    sync = 1'b1;
    push("rdy_after", ov(0, 0, 0, 0, 0, 0)); step();

    n_tests++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d expected %0d", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
